// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and hit/mispredict counters.
// Lookup is combinational (zero latency); updates, flush and counters take effect on the next clk_i edge.
// No back-pressure: lookups and updates are accepted every cycle; the caller holds lk_pc_i during stalls.
module btb_predictor #(
    parameter int PC_WIDTH  = 32,
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [PC_WIDTH-1:0]  lk_pc_i,
    output logic                 lk_hit_o,
    output logic                 lk_taken_o,
    output logic [PC_WIDTH-1:0]  lk_npc_o,
    input  logic                 upd_valid_i,
    input  logic [PC_WIDTH-1:0]  upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_jump_i,
    input  logic [PC_WIDTH-1:0]  upd_target_i,
    input  logic                 upd_mispred_i,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    // Weakly taken: MSB set, all lower bits clear.
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [PC_WIDTH-1:0] target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]    lk_idx, upd_idx;
    logic [TAG_W-1:0]    lk_tag, upd_tag;
    logic [CTR_BITS-1:0] lk_ctr, upd_ctr;
    logic                upd_hit;

    // The low two PC bits never select anything: instructions are word aligned.
    logic                unused_ok;
    assign unused_ok = ^upd_pc_i[1:0];

    assign lk_idx  = lk_pc_i[IDX_W+1:2];
    assign lk_tag  = lk_pc_i[PC_WIDTH-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[PC_WIDTH-1:IDX_W+2];

    // Lookup path reads only pre-edge state, so a same-cycle update is not bypassed.
    always_comb begin
        lk_ctr     = ctr_q[lk_idx];
        lk_hit_o   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken_o = lk_hit_o && lk_ctr[CTR_BITS-1];
        lk_npc_o   = lk_taken_o ? target_q[lk_idx] : (lk_pc_i + PC_WIDTH'(4));
    end

    // Next-state of the entry array: flush wins over update; misses allocate only on taken/jump.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_ctr  = ctr_q[upd_idx];
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (flush_i) begin
            valid_d = '0;
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_jump_i) begin
                    ctr_d[upd_idx]    = CTR_MAX;
                    target_d[upd_idx] = upd_target_i;
                end else if (upd_taken_i) begin
                    if (upd_ctr != CTR_MAX) begin
                        ctr_d[upd_idx] = upd_ctr + CTR_ONE;
                    end
                    target_d[upd_idx] = upd_target_i;
                end else if (upd_ctr != '0) begin
                    ctr_d[upd_idx] = upd_ctr - CTR_ONE;
                end
            end else if (upd_taken_i || upd_jump_i) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target_i;
                ctr_d[upd_idx]    = upd_jump_i ? CTR_MAX : CTR_WT;
            end
        end
    end

    // Saturating performance counters; flush does not touch them.
    always_comb begin
        hit_cnt_d     = hit_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (lk_hit_o && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end
        if (upd_valid_i && upd_mispred_i && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset clears every field and overrides flush and update.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            valid_q       <= '0;
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            hit_cnt_q     <= hit_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign hit_cnt_o     = hit_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Counters are built 3 bits wide so saturation is reachable in a few cycles.
module tb_btb_predictor;

    localparam int CW = 3;
    localparam logic [31:0] MISS_PC = 32'h8000_0000;

    logic          clk_i = 1'b0;
    logic          rst;
    logic          flush_i;
    logic [31:0]   lk_pc_i;
    logic          lk_hit_o;
    logic          lk_taken_o;
    logic [31:0]   lk_npc_o;
    logic          upd_valid_i;
    logic [31:0]   upd_pc_i;
    logic          upd_taken_i;
    logic          upd_jump_i;
    logic [31:0]   upd_target_i;
    logic          upd_mispred_i;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] mispred_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    btb_predictor #(
        .PC_WIDTH (32),
        .ENTRIES  (16),
        .CTR_BITS (2),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .flush_i      (flush_i),
        .lk_pc_i      (lk_pc_i),
        .lk_hit_o     (lk_hit_o),
        .lk_taken_o   (lk_taken_o),
        .lk_npc_o     (lk_npc_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_jump_i   (upd_jump_i),
        .upd_target_i (upd_target_i),
        .upd_mispred_i(upd_mispred_i),
        .hit_cnt_o    (hit_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Probe one PC inside the current cycle, then park the lookup on a PC that never hits.
    task automatic look(input string tag, input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] npc);
        lk_pc_i = pc;
        #1;
        chk({tag, ".hit"},   32'(lk_hit_o),   32'(h));
        chk({tag, ".taken"}, 32'(lk_taken_o), 32'(t));
        chk({tag, ".npc"},   lk_npc_o,        npc);
        lk_pc_i = MISS_PC;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic jp,
                       input logic [31:0] tgt, input logic mp);
        upd_valid_i   = 1'b1;
        upd_pc_i      = pc;
        upd_taken_i   = tk;
        upd_jump_i    = jp;
        upd_target_i  = tgt;
        upd_mispred_i = mp;
        tick();
        upd_valid_i   = 1'b0;
        upd_mispred_i = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int hits, input int mis);
        chk({tag, ".hit_cnt"},     32'(hit_cnt_o),     32'(hits));
        chk({tag, ".mispred_cnt"}, 32'(mispred_cnt_o), 32'(mis));
    endtask

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        lk_pc_i       = MISS_PC;
        upd_valid_i   = 1'b0;
        upd_pc_i      = '0;
        upd_taken_i   = 1'b0;
        upd_jump_i    = 1'b0;
        upd_target_i  = '0;
        upd_mispred_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        look("rst", 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0004);
        chk_cnt("rst", 0, 0);

        // Allocate on taken conditional, weakly taken; hit counter follows held lookups
        upd(32'h8000_0010, 1'b1, 1'b0, 32'h8000_0040, 1'b0);
        lk_pc_i = 32'h8000_0010;
        #1;
        chk("alloc.hit",   32'(lk_hit_o),   32'd1);
        chk("alloc.taken", 32'(lk_taken_o), 32'd1);
        chk("alloc.npc",   lk_npc_o,        32'h8000_0040);
        chk("alloc.hc0",   32'(hit_cnt_o),  32'd0);
        tick();
        chk("alloc.hc1",   32'(hit_cnt_o),  32'd1);
        tick();
        chk("alloc.hc2",   32'(hit_cnt_o),  32'd2);
        lk_pc_i = MISS_PC;

        // Counter walk: 2 -> 1 -> 0 -> 0 (sat) -> 1 -> 2 -> 3 -> 3 (sat) -> 2 -> 1
        upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        look("ctr1", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        look("ctr0", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        look("ctr0s", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        upd(32'h8000_0010, 1'b1, 1'b0, 32'h8000_0080, 1'b0);
        look("ctr1u", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        upd(32'h8000_0010, 1'b1, 1'b0, 32'h8000_0080, 1'b0);
        look("ctr2u", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0080);
        upd(32'h8000_0010, 1'b1, 1'b0, 32'h8000_0080, 1'b0);
        upd(32'h8000_0010, 1'b1, 1'b0, 32'h8000_0080, 1'b0);
        upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        look("ctr3s", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0080);
        upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        look("ctr1d", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);

        // Jump on a hit forces ctr to 3 and replaces the target
        upd(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
        look("jhit", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200);
        upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        look("jhit.nt", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200);

        // Jump on a fresh PC allocates with ctr = 3
        upd(32'h8000_0024, 1'b1, 1'b1, 32'h8000_1000, 1'b0);
        look("jnew", 32'h8000_0024, 1'b1, 1'b1, 32'h8000_1000);
        upd(32'h8000_0024, 1'b0, 1'b0, 32'h0, 1'b0);
        look("jnew.nt", 32'h8000_0024, 1'b1, 1'b1, 32'h8000_1000);

        // Not-taken miss does not allocate
        upd(32'h8000_0030, 1'b0, 1'b0, 32'h8000_3000, 1'b0);
        look("ntmiss", 32'h8000_0030, 1'b0, 1'b0, 32'h8000_0034);

        // Aliasing on index 4
        look("alias.pre50", 32'h8000_0050, 1'b0, 1'b0, 32'h8000_0054);
        look("alias.pre10", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200);
        upd(32'h8000_0050, 1'b1, 1'b0, 32'h8000_0500, 1'b0);
        look("alias.50", 32'h8000_0050, 1'b1, 1'b1, 32'h8000_0500);
        look("alias.10", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);

        // Same-cycle update and lookup: no bypass; mispredict counted
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h8000_0060;
        upd_taken_i   = 1'b1;
        upd_jump_i    = 1'b0;
        upd_target_i  = 32'h8000_0600;
        upd_mispred_i = 1'b1;
        lk_pc_i       = 32'h8000_0060;
        #1;
        chk("haz.hit0", 32'(lk_hit_o), 32'd0);
        chk("haz.npc0", lk_npc_o,      32'h8000_0064);
        tick();
        upd_valid_i   = 1'b0;
        upd_mispred_i = 1'b0;
        look("haz.next", 32'h8000_0060, 1'b1, 1'b1, 32'h8000_0600);
        chk_cnt("haz", 2, 1);

        // Flush with a simultaneous taken update: everything misses, update lost, counters kept
        tick();
        flush_i       = 1'b1;
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h8000_0070;
        upd_taken_i   = 1'b1;
        upd_jump_i    = 1'b0;
        upd_target_i  = 32'h8000_0700;
        tick();
        flush_i     = 1'b0;
        upd_valid_i = 1'b0;
        look("fl.50", 32'h8000_0050, 1'b0, 1'b0, 32'h8000_0054);
        look("fl.24", 32'h8000_0024, 1'b0, 1'b0, 32'h8000_0028);
        look("fl.60", 32'h8000_0060, 1'b0, 1'b0, 32'h8000_0064);
        look("fl.70", 32'h8000_0070, 1'b0, 1'b0, 32'h8000_0074);
        chk_cnt("fl", 2, 1);

        // Counter saturation at 3'b111
        upd(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0900, 1'b0);
        lk_pc_i = 32'h8000_0010;
        repeat (5) tick();
        chk("sat.hc7",  32'(hit_cnt_o), 32'd7);
        tick();
        chk("sat.hc7s", 32'(hit_cnt_o), 32'd7);
        lk_pc_i = MISS_PC;
        repeat (6) upd(32'h8000_0034, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("sat.mc7",  32'(mispred_cnt_o), 32'd7);
        upd(32'h8000_0034, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("sat.mc7s", 32'(mispred_cnt_o), 32'd7);

        // Reset in the middle of an update stream with a hitting lookup
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h8000_0044;
        upd_taken_i   = 1'b1;
        upd_jump_i    = 1'b0;
        upd_target_i  = 32'h8000_4400;
        upd_mispred_i = 1'b1;
        lk_pc_i       = 32'h8000_0010;
        tick();
        rst          = 1'b1;
        upd_pc_i     = 32'h8000_0048;
        upd_target_i = 32'h8000_4800;
        tick();
        rst           = 1'b0;
        upd_valid_i   = 1'b0;
        upd_mispred_i = 1'b0;
        lk_pc_i       = MISS_PC;
        chk_cnt("mrst", 0, 0);
        look("mrst.10", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);
        look("mrst.44", 32'h8000_0044, 1'b0, 1'b0, 32'h8000_0048);
        look("mrst.48", 32'h8000_0048, 1'b0, 1'b0, 32'h8000_004c);
        tick();
        chk_cnt("mrst.after", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with saturating direction counters.
- Replaces the fixed pre-decode jump logic in fetch, so the front end becomes a configurable dynamic predictor.
- The lookup port is driven by the selected fetch PC and returns the predicted next PC in the same cycle.
- The update port is driven by the resolved branch/jump result held in the execute pipeline register.

Parameters:
- PC_WIDTH, 32, width of all PC and target fields.
- ENTRIES, 16, number of BTB entries; must be a power of two and at least 2. IDX_W = log2(ENTRIES).
- CTR_BITS, 2, width of the saturating direction counter; must be at least 1.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  invalidate all entries (fence.i).
- lk_pc_i  in  PC_WIDTH  fetch PC to look up.
- lk_hit_o  out  1  valid entry with matching tag.
- lk_taken_o  out  1  predict taken (hit and counter MSB = 1).
- lk_npc_o  out  PC_WIDTH  predicted next PC.
- upd_valid_i  in  1  resolved control-flow instruction this cycle.
- upd_pc_i  in  PC_WIDTH  PC of the resolved instruction.
- upd_taken_i  in  1  actual direction.
- upd_jump_i  in  1  unconditional (jal/jalr).
- upd_target_i  in  PC_WIDTH  actual target.
- upd_mispred_i  in  1  fetch prediction was wrong.
- hit_cnt_o  out  CNT_WIDTH  lookups that hit.
- mispred_cnt_o  out  CNT_WIDTH  updates flagged as mispredicted.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[PC_WIDTH-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[PC_WIDTH-1:0], ctr[CTR_BITS-1:0].
- Lookup (combinational, zero latency):
  - lk_hit_o = valid[idx] and tag match.
  - lk_taken_o = lk_hit_o and ctr MSB.
  - lk_npc_o = target when lk_taken_o, else lk_pc_i + 4 (truncated to PC_WIDTH).
- Lookup reads pre-edge state. An update to the same entry in the same cycle becomes visible on the next cycle only; there is no bypass.
- Update on a clock edge when upd_valid_i = 1, with no reset and no flush:
  - Hit, upd_jump_i = 1: ctr <= all ones; target <= upd_target_i.
  - Hit, conditional, taken: ctr saturating increment (stops at all ones); target <= upd_target_i.
  - Hit, conditional, not taken: ctr saturating decrement (stops at 0); target is unchanged.
  - Miss and (taken or jump): allocate the entry, overwriting any alias. Set valid = 1, tag and target from the update. ctr = all ones for a jump, otherwise weakly taken (MSB = 1, rest 0; e.g. 2'b10).
  - Miss and not taken: no state change.
- Flush: on a clock edge with flush_i = 1, all valid bits are cleared.
  - Flush overrides a simultaneous update; that update is dropped.
  - Performance counters are not affected by flush.
- Reset: on a clock edge with rst = 1:
  - All valid bits = 0, ctr = 0, target = 0, tag = 0.
  - hit_cnt_o = 0 and mispred_cnt_o = 0.
  - Reset overrides flush and update.
  - Reset asserted mid-stream takes effect on the next edge and is identical to power-on reset.
- Outputs after reset:
  - lk_hit_o = 0, lk_taken_o = 0, lk_npc_o = lk_pc_i + 4.
  - Both counters read 0.
- Performance counters:
  - hit_cnt_o increments on every edge where lk_hit_o = 1.
  - mispred_cnt_o increments on every edge where upd_valid_i and upd_mispred_i are both 1.
  - Both saturate at all ones (no wrap). Neither counts during reset.
- The block has no handshake back-pressure. The pipeline's stall logic must hold lk_pc_i stable; repeated lookups are harmless apart from hit_cnt_o.
- Implementation: flop array, no SRAM macro. Target is 120–400 lines of RTL.

Test Plan (defaults: ENTRIES=16, CTR_BITS=2, PC_WIDTH=32):
1. Reset released, lookup 0x80000000 -> hit=0, taken=0, npc=0x80000004; both counters 0.
2. Update pc=0x80000010, taken, target=0x80000040, conditional; next cycle look up 0x80000010 -> hit=1, ctr=2'b10, taken=1, npc=0x80000040; hit_cnt increments by 1 per cycle held.
3. Counter saturation on pc=0x80000010:
   - 2 not-taken updates -> ctr=0, npc=0x80000014.
   - 1 taken update -> ctr=1, still not taken.
   - 2 taken updates -> ctr=3.
   - A further taken update -> ctr stays 3.
   - Jump update on a fresh pc -> ctr=3 immediately.
4. Aliasing: with 0x80000010 installed, look up 0x80000050 (same index, different tag) -> hit=0. A taken update on 0x80000050 replaces the entry, after which 0x80000010 misses.
5. Same-cycle hazard: update (allocate) and lookup of the same pc in one cycle -> lookup returns hit=0 that cycle and hit=1 the next. An update with upd_mispred_i=1 -> mispred_cnt increments by 1.
6. Priority:
   - flush_i together with a taken update -> all lookups miss next cycle and the update is lost; counters are retained.
   - rst during a stream of updates -> all entries invalid and both counters 0 on the next cycle.
